dram_stream_ctrl: RTL and testbench



---
 rtl/dram_stream_pkg.sv | 28 ++
 rtl/dram_stream_ctrl_sync_fifo.sv | 64 ++++++
 rtl/dram_stream_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_dram_stream_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_stream_pkg.sv
// dram_stream_pkg
// Shared types for the DRAM stream controller.
//   rd_state_t : read-side burst FSM states (IDLE, BURST)
//   tag_t      : return-path tag {valid, ch, last} that travels alongside each
//                issued read address until its data comes back from the pins
//   ch_width() : width of a channel index for a given client count (min 1)
package dram_stream_pkg;

  // Upper bound on the channel index width carried in a tag; the top only
  // uses the low ch_width(N_RD) bits.
  localparam int CH_MAX_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
    logic                last;
  } tag_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_stream_ctrl_sync_fifo.sv
// sync_fifo
// Single-clock FIFO used as the writeback buffer.
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write wdata when wr_ready is high (push while full is ignored)
//   pop       : drop the head entry when not empty
//   rdata     : current head entry (valid while !empty)
//   wr_ready  : registered "not full"
//   empty     : no entries stored
// Push and pop in the same cycle leave the count unchanged. No fall-through:
// a pushed word becomes visible at the head one edge after the push.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     pop,
  output logic signed [DATA_W-1:0] rdata,
  output logic                     wr_ready,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign push_ok = push & wr_ready;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_ok && pop_ok)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      wr_ready <= (cnt_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dram_stream_ctrl.sv
// dram_stream_ctrl
// Off-chip memory port controller between the CNN/LSTM datapath and the DRAM
// pins.
//   Read side : N_RD clients post bursts (i_rd_req/i_rd_base/i_rd_len). One is
//               granted per IDLE cycle (o_rd_ack pulse), its addresses are
//               driven on o_DRAM_1_addr one per cycle, and i_DRAM_out_data is
//               returned RD_LAT edges later on o_rd_valid/o_rd_data/o_rd_ch/
//               o_rd_last. o_rd_busy covers issuing and in-flight beats.
//   Write side: i_wr_valid/i_wr_data fill a WB_DEPTH FIFO (o_wr_ready = not
//               full); the FIFO drains one word per cycle onto o_DRAM_in3_*
//               at an auto-incrementing address (i_wr_base_load/i_wr_base).
//   Clock/reset: i_clk, synchronous active-high i_reset. All outputs registered.
// Build option: define DRAM_STREAM_RR_EN for round-robin arbitration;
// otherwise the lowest requesting channel index wins.
module dram_stream_ctrl
  import dram_stream_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 13,
  parameter int N_RD     = 2,
  parameter int LEN_W    = 8,
  parameter int RD_LAT   = 2,
  parameter int WB_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_RD-1:0]               i_rd_req,
  input  logic [N_RD*ADDR_W-1:0]        i_rd_base,
  input  logic [N_RD*LEN_W-1:0]         i_rd_len,
  output logic [N_RD-1:0]               o_rd_ack,
  output logic                          o_rd_valid,
  output logic [ch_width(N_RD)-1:0]     o_rd_ch,
  output logic signed [DATA_W-1:0]      o_rd_data,
  output logic                          o_rd_last,
  output logic                          o_rd_busy,
  input  logic                          i_wr_valid,
  input  logic signed [DATA_W-1:0]      i_wr_data,
  output logic                          o_wr_ready,
  input  logic                          i_wr_base_load,
  input  logic [ADDR_W-1:0]             i_wr_base,
  output logic [ADDR_W-1:0]             o_DRAM_1_addr,
  input  logic signed [DATA_W-1:0]      i_DRAM_out_data,
  output logic                          o_DRAM_in3_WEN,
  output logic signed [DATA_W-1:0]      o_DRAM_in3_Data,
  output logic [ADDR_W-1:0]             o_DRAM_in3_addr
);

  localparam int CH_W = ch_width(N_RD);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic [CH_W-1:0]   ch_q;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_ch;
  logic              issue;
  tag_t              tag_in;
  tag_t              tag_p [RD_LAT];
  logic              busy_d;

  // Arbitration (evaluated only while IDLE)
`ifdef DRAM_STREAM_RR_EN
  logic [CH_W-1:0] rr_ptr_q;

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int i = 0; i < N_RD; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_RD;
      if (!gnt_any && i_rd_req[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      rr_ptr_q <= '0;
    else if (state_q == IDLE && gnt_any)
      rr_ptr_q <= (gnt_ch == CH_W'(N_RD - 1)) ? '0 : gnt_ch + CH_W'(1);
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    // Descending scan so the lowest requesting index is the last one written.
    for (int i = N_RD - 1; i >= 0; i--) begin
      if (i_rd_req[i]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
  end
`endif

  // Burst FSM: IDLE takes the grant; BURST issues one address per cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:  if (gnt_any) state_d = BURST;
      BURST: begin
        issue = 1'b1;
        if (beat_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.ch    = CH_MAX_W'(ch_q);
    tag_in.last  = issue && (beat_q == len_q);
  end

  // The registered busy flag looks at the next-cycle state and tags so that
  // it lines up with the registered address and tag pipeline.
  always_comb begin
    busy_d = (state_d == BURST) | tag_in.valid;
    for (int i = 0; i < RD_LAT - 1; i++)
      busy_d = busy_d | tag_p[i].valid;
  end

  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && gnt_any) begin
      base_q <= i_rd_base[int'(gnt_ch)*ADDR_W +: ADDR_W];
      len_q  <= i_rd_len[int'(gnt_ch)*LEN_W +: LEN_W];
      ch_q   <= gnt_ch;
    end
  end

  // Issue stage: address pins, grant pulse, tag pipeline entry
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      o_rd_ack      <= '0;
      o_DRAM_1_addr <= '0;
      o_rd_busy     <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_rd_busy <= busy_d;
      o_rd_ack  <= (issue && beat_q == '0) ? (N_RD'(1) << ch_q) : '0;
      if (state_q == IDLE)
        beat_q <= '0;
      else if (issue)
        beat_q <= beat_q + LEN_W'(1);
      if (issue)
        o_DRAM_1_addr <= base_q + ADDR_W'(beat_q);
    end
  end

  // Tag pipeline: RD_LAT stages between address edge and data sample edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Return stage: sample the data pins under the oldest tag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rd_valid <= 1'b0;
      o_rd_ch    <= '0;
      o_rd_last  <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= tag_p[RD_LAT-1].valid;
      o_rd_last  <= tag_p[RD_LAT-1].valid & tag_p[RD_LAT-1].last;
      if (tag_p[RD_LAT-1].valid) begin
        o_rd_ch   <= tag_p[RD_LAT-1].ch[CH_W-1:0];
        o_rd_data <= i_DRAM_out_data;
      end
    end
  end

  // Writeback buffer and drain
  logic                     wb_push, wb_pop, wb_empty;
  logic signed [DATA_W-1:0] wb_head;
  logic [ADDR_W-1:0]        wcnt_q;

  assign wb_push = i_wr_valid & o_wr_ready;
  assign wb_pop  = ~wb_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (WB_DEPTH)
  ) u_wb_fifo (
    .clk      (i_clk),
    .rst      (i_reset),
    .push     (wb_push),
    .wdata    (i_wr_data),
    .pop      (wb_pop),
    .rdata    (wb_head),
    .wr_ready (o_wr_ready),
    .empty    (wb_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wcnt_q          <= '0;
      o_DRAM_in3_WEN  <= 1'b0;
      o_DRAM_in3_Data <= '0;
      o_DRAM_in3_addr <= '0;
    end else begin
      o_DRAM_in3_WEN <= wb_pop;
      if (wb_pop) begin
        o_DRAM_in3_Data <= wb_head;
        o_DRAM_in3_addr <= wcnt_q;
      end
      // A load wins over the increment; the write in this cycle already
      // captured the old counter value above.
      if (i_wr_base_load)
        wcnt_q <= i_wr_base;
      else if (wb_pop)
        wcnt_q <= wcnt_q + ADDR_W'(1);
    end
  end

  // Pushing into a full buffer loses data.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_wr_valid)
      assert (o_wr_ready);
  end

endmodule

// File: tb/tb_dram_stream_ctrl.sv
// tb_dram_stream_ctrl
// Directed self-checking bench for dram_stream_ctrl with default parameters
// (DATA_W 8, ADDR_W 13, N_RD 2, LEN_W 8, RD_LAT 2, WB_DEPTH 8). The DRAM model
// returns addr[7:0] for each read address, delayed to match RD_LAT 2.
module tb_dram_stream_ctrl;

  localparam int DATA_W = 8, ADDR_W = 13, N_RD = 2, LEN_W = 8, RD_LAT = 2, WB_DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_RD-1:0]          rd_req;
  logic [N_RD*ADDR_W-1:0]   rd_base;
  logic [N_RD*LEN_W-1:0]    rd_len;
  logic [N_RD-1:0]          rd_ack;
  logic                     rd_valid;
  logic [0:0]               rd_ch;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_last, rd_busy;
  logic                     wr_valid;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_ready, wr_base_load;
  logic [ADDR_W-1:0]        wr_base;
  logic [ADDR_W-1:0]        dram_addr;
  logic signed [DATA_W-1:0] dram_rdata;
  logic                     dram_wen;
  logic signed [DATA_W-1:0] dram_wdata;
  logic [ADDR_W-1:0]        dram_waddr;

  always #5 clk = ~clk;

  dram_stream_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .LEN_W(LEN_W),
    .RD_LAT(RD_LAT), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rd_req(rd_req), .i_rd_base(rd_base), .i_rd_len(rd_len),
    .o_rd_ack(rd_ack), .o_rd_valid(rd_valid), .o_rd_ch(rd_ch),
    .o_rd_data(rd_data), .o_rd_last(rd_last), .o_rd_busy(rd_busy),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_wr_base_load(wr_base_load), .i_wr_base(wr_base),
    .o_DRAM_1_addr(dram_addr), .i_DRAM_out_data(dram_rdata),
    .o_DRAM_in3_WEN(dram_wen), .o_DRAM_in3_Data(dram_wdata),
    .o_DRAM_in3_addr(dram_waddr)
  );

  // DRAM read model: the address seen after edge E is answered in time for
  // the sampling edge E+2.
  logic signed [7:0] dram_q;
  always @(posedge clk) dram_q <= dram_addr[7:0];
  assign dram_rdata = dram_q;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitors
  logic [0:0]  bch_q[$];
  logic [7:0]  bdata_q[$];
  logic        blast_q[$];
  int          bcyc_q[$];
  logic [7:0]  wdata_q[$];
  logic [12:0] waddr_q[$];

  always @(negedge clk) begin
    if (rd_valid) begin
      bch_q.push_back(rd_ch);
      bdata_q.push_back(rd_data);
      blast_q.push_back(rd_last);
      bcyc_q.push_back(cyc);
    end
    if (dram_wen) begin
      wdata_q.push_back(dram_wdata);
      waddr_q.push_back(dram_waddr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    bch_q.delete(); bdata_q.delete(); blast_q.delete(); bcyc_q.delete();
    wdata_q.delete(); waddr_q.delete();
  endtask

  task automatic set_req(input int ch, input logic [12:0] base, input logic [7:0] len, input logic on);
    rd_req[ch] = on;
    rd_base[ch*ADDR_W +: ADDR_W] = base;
    rd_len[ch*LEN_W +: LEN_W] = len;
  endtask

  task automatic wait_rd_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (!rd_busy && !rd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset;
    logic [N_RD+1+1+DATA_W+1+1-1:0] rd_bundle;
    logic [1+1+DATA_W+ADDR_W-1:0]   wr_bundle;
    rst = 1'b1;
    tick(); tick();
    rd_bundle = {rd_ack, rd_valid, rd_ch, rd_data, rd_last, rd_busy};
    wr_bundle = {wr_ready, dram_wen, dram_wdata, dram_waddr};
    checks++;
    if (rd_bundle !== '0) $display("FAIL reset_rd_outputs got %0h want 0", rd_bundle);
    else passed++;
    checks++;
    if (wr_bundle !== {1'b1, 1'b0, 8'h00, 13'h0000}) $display("FAIL reset_wr_outputs got %0h want %0h", wr_bundle, {1'b1, 22'h0});
    else passed++;
    checks++;
    if (dram_addr !== 13'h0) $display("FAIL reset_rd_addr got %0h want 0", dram_addr);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_burst;
    int ack_cyc;
    bit ok;
    logic [12:0] exp_addr [4];
    exp_addr[0] = 13'h0FFE; exp_addr[1] = 13'h0FFF; exp_addr[2] = 13'h1000; exp_addr[3] = 13'h1001;
    clear_q();
    set_req(0, 13'h0FFE, 8'd3, 1'b1);
    tick();
    checks++;
    if (rd_ack !== 2'b00) $display("FAIL burst_ack_early got %b want 00", rd_ack);
    else passed++;
    tick();
    ack_cyc = cyc;
    checks++;
    if (rd_ack !== 2'b01) $display("FAIL burst_ack got %b want 01", rd_ack);
    else passed++;
    set_req(0, 13'h0FFE, 8'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (dram_addr !== exp_addr[k]) $display("FAIL burst_addr%0d got %h want %h", k, dram_addr, exp_addr[k]);
      else passed++;
    end
    wait_rd_idle(ok);
    checks++;
    if (!ok) $display("FAIL burst_idle_timeout busy=%b want 0", rd_busy);
    else passed++;
    checks++;
    if (bdata_q.size() != 4) $display("FAIL burst_beats got %0d want 4", bdata_q.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({bch_q[k], bdata_q[k], blast_q[k]} !== {1'b0, exp_addr[k][7:0], (k == 3)})
          $display("FAIL burst_beat%0d got ch=%0d data=%h last=%b want ch=0 data=%h last=%b",
                   k, bch_q[k], bdata_q[k], blast_q[k], exp_addr[k][7:0], (k == 3));
        else passed++;
      end
      checks++;
      if (bcyc_q[0] - ack_cyc != 2) $display("FAIL burst_latency got %0d want 2", bcyc_q[0] - ack_cyc);
      else passed++;
    end
  endtask

  task automatic test_len0_wrap;
    bit ok;
    clear_q();
    set_req(0, 13'h1FFF, 8'd0, 1'b1);
    tick(); tick();
    checks++;
    if ({rd_ack, dram_addr} !== {2'b01, 13'h1FFF}) $display("FAIL len0_issue got ack=%b addr=%h want ack=01 addr=1fff", rd_ack, dram_addr);
    else passed++;
    set_req(0, 13'h1FFF, 8'd0, 1'b0);
    wait_rd_idle(ok);
    checks++;
    if (!ok) $display("FAIL len0_idle_timeout busy=%b want 0", rd_busy);
    else passed++;
    checks++;
    if (bdata_q.size() != 1) $display("FAIL len0_beats got %0d want 1", bdata_q.size());
    else if ({bch_q[0], bdata_q[0], blast_q[0]} !== {1'b0, 8'hFF, 1'b1})
      $display("FAIL len0_beat got ch=%0d data=%h last=%b want ch=0 data=ff last=1", bch_q[0], bdata_q[0], blast_q[0]);
    else passed++;
  endtask

  task automatic test_arbitration;
    logic [1:0] acks[$];
    logic [1:0] exp [5];
    bit ok;
`ifdef DRAM_STREAM_RR_EN
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10; exp[4] = 2'b10;
`else
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b01; exp[4] = 2'b10;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    clear_q();
    set_req(0, 13'h0020, 8'd0, 1'b1);
    set_req(1, 13'h0040, 8'd0, 1'b1);
    for (int n = 0; n < 80 && acks.size() < 5; n++) begin
      tick();
      if (rd_ack != 2'b00) begin
        acks.push_back(rd_ack);
        if (acks.size() == 4) rd_req[0] = 1'b0;
        if (acks.size() == 5) rd_req[1] = 1'b0;
      end
    end
    rd_req = '0;
    wait_rd_idle(ok);
    checks++;
    if (acks.size() != 5 || !ok) $display("FAIL arb_ack_count got %0d want 5", acks.size());
    else begin
      passed++;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acks[k] !== exp[k]) $display("FAIL arb_grant%0d got %b want %b", k, acks[k], exp[k]);
        else passed++;
      end
    end
    checks++;
    if (bdata_q.size() != 5) $display("FAIL arb_beats got %0d want 5", bdata_q.size());
    else begin
      passed++;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (bdata_q[k] !== (bch_q[k] ? 8'h40 : 8'h20) || bch_q[k] !== exp[k][1] || blast_q[k] !== 1'b1)
          $display("FAIL arb_beat%0d got ch=%0d data=%h last=%b want ch=%0d", k, bch_q[k], bdata_q[k], blast_q[k], exp[k][1]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    set_req(0, 13'h0100, 8'd5, 1'b1);
    tick(); tick();
    set_req(0, 13'h0100, 8'd5, 1'b0);
    tick(); tick();
    checks++;
    if (dram_addr !== 13'h0102) $display("FAIL midrst_beat2_addr got %h want 0102", dram_addr);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if ({rd_valid, rd_busy, rd_ack, rd_ch, rd_data, rd_last} !== '0 || dram_addr !== 13'h0)
      $display("FAIL midrst_outputs got valid=%b busy=%b ack=%b addr=%h want all 0", rd_valid, rd_busy, rd_ack, dram_addr);
    else passed++;
    checks++;
    if ({wr_ready, dram_wen, dram_waddr} !== {1'b1, 1'b0, 13'h0}) $display("FAIL midrst_wr got ready=%b wen=%b addr=%h want 1 0 0", wr_ready, dram_wen, dram_waddr);
    else passed++;
    rst = 1'b0;
    clear_q();
    tick(); tick(); tick(); tick();
    checks++;
    if (bdata_q.size() != 0 || rd_busy !== 1'b0) $display("FAIL midrst_stale_beats got %0d busy=%b want 0", bdata_q.size(), rd_busy);
    else passed++;
    set_req(1, 13'h0030, 8'd1, 1'b1);
    tick(); tick();
    checks++;
    if ({rd_ack, dram_addr} !== {2'b10, 13'h0030}) $display("FAIL midrst_new_issue got ack=%b addr=%h want ack=10 addr=0030", rd_ack, dram_addr);
    else passed++;
    set_req(1, 13'h0030, 8'd1, 1'b0);
    wait_rd_idle(ok);
    checks++;
    if (!ok || bdata_q.size() != 2) $display("FAIL midrst_new_beats got %0d want 2", bdata_q.size());
    else if ({bch_q[0], bdata_q[0], blast_q[0], bch_q[1], bdata_q[1], blast_q[1]} !== {1'b1, 8'h30, 1'b0, 1'b1, 8'h31, 1'b1})
      $display("FAIL midrst_new_data got %h,%h last=%b%b want 30,31 last=01", bdata_q[0], bdata_q[1], blast_q[0], blast_q[1]);
    else passed++;
  endtask

  task automatic test_writeback;
    bit ready_ok = 1'b1;
    clear_q();
    wr_base_load = 1'b1; wr_base = 13'h0100;
    tick();
    wr_base_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wr_valid = 1'b1; wr_data = 8'(k);
      if (!wr_ready) ready_ok = 1'b0;
      tick();
      if (k == 1) begin
        checks++;
        if (dram_wen !== 1'b0) $display("FAIL wb_no_fallthrough got wen=%b want 0", dram_wen);
        else passed++;
      end
    end
    wr_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (!ready_ok) $display("FAIL wb_ready got 0 want 1");
    else passed++;
    checks++;
    if (wdata_q.size() != 10) $display("FAIL wb_count got %0d want 10", wdata_q.size());
    else begin
      passed++;
      for (int k = 0; k < 10; k++) begin
        checks++;
        if ({wdata_q[k], waddr_q[k]} !== {8'(k + 1), 13'(13'h0100 + k)})
          $display("FAIL wb_write%0d got data=%h addr=%h want data=%h addr=%h", k, wdata_q[k], waddr_q[k], 8'(k + 1), 13'(13'h0100 + k));
        else passed++;
      end
    end
  endtask

  task automatic test_load_collision;
    logic [12:0] exp_a;
    clear_q();
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h21 + k);
      wr_base_load = (k == 1); wr_base = 13'h0200;
      tick();
    end
    wr_valid = 1'b0; wr_base_load = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (wdata_q.size() != 8) $display("FAIL load_count got %0d want 8", wdata_q.size());
    else begin
      passed++;
      for (int k = 0; k < 8; k++) begin
        exp_a = (k == 0) ? 13'h010A : 13'(13'h0200 + k - 1);
        checks++;
        if ({wdata_q[k], waddr_q[k]} !== {8'(8'h21 + k), exp_a})
          $display("FAIL load_write%0d got data=%h addr=%h want data=%h addr=%h", k, wdata_q[k], waddr_q[k], 8'(8'h21 + k), exp_a);
        else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, passed=%0d of %0d", passed, checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_req = '0; rd_base = '0; rd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_base_load = 1'b0; wr_base = '0;
    test_reset();
    test_single_burst();
    test_len0_wrap();
    test_arbitration();
    test_reset_mid_burst();
    test_writeback();
    test_load_collision();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
